// File: rtl/obi_buffered_cut_pkg.sv
// Shared OBI configuration and default channel/bundle types for the buffered cut.
// Callers with their own channel structs pass them in through the type parameters.
package obi_buffered_cut_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiBeWidth   = ObiDataWidth / 8;

  // Bus configuration; UseRReady says whether the subordinate port carries rready.
  typedef struct packed {
    logic       UseRReady;
    logic [7:0] AddrWidth;
    logic [7:0] DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    UseRReady: 1'b0,
    AddrWidth: 8'(ObiAddrWidth),
    DataWidth: 8'(ObiDataWidth)
  };

  // Default A channel payload.
  typedef struct packed {
    logic [ObiAddrWidth-1:0] addr;
    logic                    we;
    logic [ObiBeWidth-1:0]   be;
    logic [ObiDataWidth-1:0] wdata;
  } obi_def_a_chan_t;

  // Default R channel payload.
  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic                    err;
  } obi_def_r_chan_t;

  // Request bundle; rready is present but only honoured when UseRReady is set.
  typedef struct packed {
    obi_def_a_chan_t a;
    logic            req;
    logic            rready;
  } obi_def_req_t;

  // Response bundle.
  typedef struct packed {
    obi_def_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } obi_def_rsp_t;

endpackage

// File: rtl/obi_buffered_cut_fifo.sv
// Registered-output FIFO (no fall-through) used for both the A and R channels.
// A push into a full FIFO and a pop from an empty FIFO are silently ignored.
module obi_buffered_cut_fifo #(
  parameter int unsigned Depth      = 2,
  parameter type         dtype_t    = logic,
  parameter int unsigned UsageWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_push,
  input  dtype_t                i_data,
  output logic                  o_full,
  input  logic                  i_pop,
  output dtype_t                o_data,
  output logic                  o_empty,
  output logic [UsageWidth-1:0] o_usage
);

  localparam int unsigned           PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(Depth - 1);
  localparam logic [PtrWidth-1:0]   PtrOne    = PtrWidth'(1);
  localparam logic [UsageWidth-1:0] FullCount = UsageWidth'(Depth);
  localparam logic [UsageWidth-1:0] CountOne  = UsageWidth'(1);

  dtype_t                r_mem [Depth];
  logic [PtrWidth-1:0]   r_wrPtr;
  logic [PtrWidth-1:0]   r_rdPtr;
  logic [UsageWidth-1:0] r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  // Pointers wrap at Depth so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrOne;
  endfunction

  assign o_full   = (r_count == FullCount);
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_data   = r_mem[r_rdPtr];
  assign o_usage  = r_count;

  // Pointer and occupancy bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CountOne;
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - CountOne;
      end
    end
  end

  // Storage needs no reset: the consumer only looks at it while non-empty.
  always_ff @(posedge clk_i) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/obi_credit_counter.sv
// Saturating up/down counter tracking transactions in flight through the cut.
// o_avail says another transaction may be issued without overrunning the limit.
module obi_credit_counter #(
  parameter int unsigned MaxCount = 2,
  parameter int unsigned CntWidth = $clog2(MaxCount + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_inc,
  input  logic                i_dec,
  output logic [CntWidth-1:0] o_count,
  output logic                o_avail
);

  localparam logic [CntWidth-1:0] MaxVal = CntWidth'(MaxCount);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0] r_count;
  logic                w_doInc;
  logic                w_doDec;

  assign o_avail = (r_count < MaxVal);
  assign o_count = r_count;
  assign w_doInc = i_inc & o_avail;
  assign w_doDec = i_dec & (r_count != '0);

  // Issue and retire in the same cycle leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (w_doInc && !w_doDec) begin
      r_count <= r_count + CntOne;
    end else if (w_doDec && !w_doInc) begin
      r_count <= r_count - CntOne;
    end
  end

  // Retiring with nothing in flight means the response path lost track.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(i_dec && (r_count == '0)));

  // Issuing without credit means the caller ignored o_avail.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(i_inc && !o_avail));

endmodule

// File: rtl/obi_buffered_cut.sv
// Buffered OBI cut: request FIFO on A, response FIFO on R, and a credit counter
// that caps in-flight transactions at RspDepth so responses always have a slot.
module obi_buffered_cut
  import obi_buffered_cut_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg       = ObiDefaultConfig,
  parameter type         obi_a_chan_t = obi_def_a_chan_t,
  parameter type         obi_r_chan_t = obi_def_r_chan_t,
  parameter type         obi_req_t    = obi_def_req_t,
  parameter type         obi_rsp_t    = obi_def_rsp_t,
  parameter int unsigned ReqDepth     = 2,
  parameter int unsigned RspDepth     = 2,
  parameter bit          MgrUseRReady = 1'b0,
  parameter int unsigned CntWidth     = $clog2(RspDepth + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  obi_req_t                       sbr_port_req_i,
  output obi_rsp_t                       sbr_port_rsp_o,
  output obi_req_t                       mgr_port_req_o,
  input  obi_rsp_t                       mgr_port_rsp_i,
  output logic [CntWidth-1:0]            outstanding_o,
  output logic [$clog2(ReqDepth+1)-1:0]  req_fill_o
);

  localparam int unsigned ReqFillWidth = $clog2(ReqDepth + 1);

  logic                    w_reqFull;
  logic                    w_reqEmpty;
  logic                    w_reqPush;
  logic                    w_reqPop;
  obi_a_chan_t             w_reqHead;
  logic [ReqFillWidth-1:0] w_reqUsage;

  logic                    w_rspFull;
  logic                    w_rspEmpty;
  logic                    w_rspPush;
  logic                    w_rspPop;
  obi_r_chan_t             w_rspHead;
  logic [CntWidth-1:0]     w_rspUsage;

  logic                    w_creditAvail;
  logic [CntWidth-1:0]     w_outstanding;
  logic                    w_mgrReq;
  logic                    w_mgrRReady;
  logic                    w_rreadyEff;

  // Request side: accept while there is room, issue the head only with credit.
  assign w_reqPush = sbr_port_req_i.req & ~w_reqFull;
  assign w_mgrReq  = ~w_reqEmpty & w_creditAvail;
  assign w_reqPop  = w_mgrReq & mgr_port_rsp_i.gnt;

  // Response side: a downstream without rready is always accepted, credit
  // having already reserved the slot.
  assign w_mgrRReady = MgrUseRReady ? ~w_rspFull : 1'b1;
  assign w_rspPush   = mgr_port_rsp_i.rvalid & w_mgrRReady;
  assign w_rreadyEff = ObiCfg.UseRReady ? sbr_port_req_i.rready : 1'b1;
  assign w_rspPop    = ~w_rspEmpty & w_rreadyEff;

  obi_buffered_cut_fifo #(
    .Depth   (ReqDepth),
    .dtype_t (obi_a_chan_t)
  ) u_reqFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_reqPush),
    .i_data  (sbr_port_req_i.a),
    .o_full  (w_reqFull),
    .i_pop   (w_reqPop),
    .o_data  (w_reqHead),
    .o_empty (w_reqEmpty),
    .o_usage (w_reqUsage)
  );

  obi_buffered_cut_fifo #(
    .Depth   (RspDepth),
    .dtype_t (obi_r_chan_t)
  ) u_rspFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_rspPush),
    .i_data  (mgr_port_rsp_i.r),
    .o_full  (w_rspFull),
    .i_pop   (w_rspPop),
    .o_data  (w_rspHead),
    .o_empty (w_rspEmpty),
    .o_usage (w_rspUsage)
  );

  obi_credit_counter #(
    .MaxCount (RspDepth),
    .CntWidth (CntWidth)
  ) u_credit (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_inc   (w_reqPop),
    .i_dec   (w_rspPop),
    .o_count (w_outstanding),
    .o_avail (w_creditAvail)
  );

  // Upstream response; payload forced to zero while nothing is buffered.
  always_comb begin
    sbr_port_rsp_o        = '0;
    sbr_port_rsp_o.gnt    = ~w_reqFull;
    sbr_port_rsp_o.rvalid = ~w_rspEmpty;
    sbr_port_rsp_o.r      = w_rspEmpty ? '0 : w_rspHead;
  end

  // Downstream request; the head stays put until granted, so a and req are stable.
  always_comb begin
    mgr_port_req_o        = '0;
    mgr_port_req_o.req    = w_mgrReq;
    mgr_port_req_o.a      = w_reqEmpty ? '0 : w_reqHead;
    mgr_port_req_o.rready = w_mgrRReady;
  end

  assign outstanding_o = w_outstanding;
  assign req_fill_o    = w_reqUsage;

  // Buffered responses can never exceed what has been issued and not delivered.
  assert property (@(posedge clk_i) disable iff (!rst_ni) w_rspUsage <= w_outstanding);

  // A downstream that cannot be stalled must never find the buffer full.
  if (!MgrUseRReady) begin : gNoStallCheck
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(mgr_port_rsp_i.rvalid && w_rspFull));
  end

endmodule

// File: tb/tb_obi_buffered_cut.sv
// Directed bench for obi_buffered_cut: one instance with upstream rready, one without.
module tb_obi_buffered_cut;
  import obi_buffered_cut_pkg::*;

  localparam obi_cfg_t CfgRReady = '{UseRReady: 1'b1, AddrWidth: 8'd32, DataWidth: 8'd32};

  logic         clk;
  logic         rstN;
  obi_def_req_t req0, mreq0, req1, mreq1;
  obi_def_rsp_t rsp0, mrsp0, rsp1, mrsp1;
  logic [1:0]   outst0, fill0, outst1, fill1;

  int           checkCount = 0;
  int           failCount  = 0;

  int           sendIdx, grantIdx, recvIdx, cyc;
  logic         pendValid, nextValid;
  logic [31:0]  pendData, nextData;

  obi_buffered_cut #(
    .ObiCfg       (CfgRReady),
    .ReqDepth     (2),
    .RspDepth     (2),
    .MgrUseRReady (1'b0)
  ) u_dutRReady (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .sbr_port_req_i (req0),
    .sbr_port_rsp_o (rsp0),
    .mgr_port_req_o (mreq0),
    .mgr_port_rsp_i (mrsp0),
    .outstanding_o  (outst0),
    .req_fill_o     (fill0)
  );

  obi_buffered_cut #(
    .ObiCfg       (ObiDefaultConfig),
    .ReqDepth     (2),
    .RspDepth     (2),
    .MgrUseRReady (1'b0)
  ) u_dutNoRReady (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .sbr_port_req_i (req1),
    .sbr_port_rsp_o (rsp1),
    .mgr_port_req_o (mreq1),
    .mgr_port_rsp_i (mrsp1),
    .outstanding_o  (outst1),
    .req_fill_o     (fill1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] bench did not terminate");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives the rready-capable instance, then lets combinational outputs settle.
  task automatic applyStimulus(input logic sbrReq, input logic [31:0] addr,
                               input logic sbrRReady, input logic mgrGnt,
                               input logic mgrRValid, input logic [31:0] rdata);
    req0.req     = sbrReq;
    req0.a.addr  = addr;
    req0.a.we    = 1'b0;
    req0.a.be    = 4'hF;
    req0.a.wdata = ~addr;
    req0.rready  = sbrRReady;
    mrsp0.gnt     = mgrGnt;
    mrsp0.rvalid  = mgrRValid;
    mrsp0.r.rdata = rdata;
    mrsp0.r.err   = 1'b0;
    #1;
  endtask

  // Same for the instance without upstream rready; its rready input stays 0.
  task automatic applyStimulusAlt(input logic sbrReq, input logic [31:0] addr,
                                  input logic mgrGnt, input logic mgrRValid,
                                  input logic [31:0] rdata);
    req1.req      = sbrReq;
    req1.a.addr   = addr;
    req1.a.we     = 1'b0;
    req1.a.be     = 4'hF;
    req1.a.wdata  = '0;
    req1.rready   = 1'b0;
    mrsp1.gnt     = mgrGnt;
    mrsp1.rvalid  = mgrRValid;
    mrsp1.r.rdata = rdata;
    mrsp1.r.err   = 1'b0;
    #1;
  endtask

  initial begin
    rstN  = 1'b0;
    req0  = '0;
    mrsp0 = '0;
    req1  = '0;
    mrsp1 = '0;
    #2;

    $display("[TB] reset values");
    checkOutput("rst_gnt",         32'(rsp0.gnt),      32'd1);
    checkOutput("rst_mreq",        32'(mreq0.req),     32'd0);
    checkOutput("rst_rvalid",      32'(rsp0.rvalid),   32'd0);
    checkOutput("rst_rdata",       rsp0.r.rdata,       32'd0);
    checkOutput("rst_maddr",       mreq0.a.addr,       32'd0);
    checkOutput("rst_mrready",     32'(mreq0.rready),  32'd1);
    checkOutput("rst_outst",       32'(outst0),        32'd0);
    checkOutput("rst_fill",        32'(fill0),         32'd0);
    checkOutput("rst_alt_gnt",     32'(rsp1.gnt),      32'd1);
    checkOutput("rst_alt_mrready", 32'(mreq1.rready),  32'd1);

    @(negedge clk);
    rstN = 1'b1;
    nextCycle();

    $display("[TB] request back-pressure and credit");
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("a_gnt_empty", 32'(rsp0.gnt), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("a_mreq_latency", 32'(mreq0.req), 32'd1);
    checkOutput("a_maddr0",       mreq0.a.addr,   32'h100);
    checkOutput("a_fill1",        32'(fill0),     32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("a_gnt_full", 32'(rsp0.gnt), 32'd0);
    checkOutput("a_fill2",    32'(fill0),    32'd2);
    nextCycle();
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("a_full_pop_gnt", 32'(rsp0.gnt),  32'd0);
    checkOutput("a_stall_maddr",  mreq0.a.addr,    32'h100);
    nextCycle();
    applyStimulus(1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("a_after_pop_fill", 32'(fill0),    32'd1);
    checkOutput("a_after_pop_gnt",  32'(rsp0.gnt), 32'd1);
    checkOutput("a_outst1",         32'(outst0),   32'd1);
    checkOutput("a_maddr1",         mreq0.a.addr,  32'h104);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA100);
    checkOutput("c_outst_max",   32'(outst0),    32'd2);
    checkOutput("c_fill_held",   32'(fill0),     32'd1);
    checkOutput("c_no_credit",   32'(mreq0.req), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA104);
    checkOutput("r_rvalid_latency", 32'(rsp0.rvalid), 32'd1);
    checkOutput("r_rdata0",         rsp0.r.rdata,     32'hA100);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("r_hold_rvalid", 32'(rsp0.rvalid), 32'd1);
    checkOutput("c_outst_hold",  32'(outst0),      32'd2);
    checkOutput("c_still_none",  32'(mreq0.req),   32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("r_rdata0_held", rsp0.r.rdata, 32'hA100);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("c_freed_outst", 32'(outst0),    32'd1);
    checkOutput("c_freed_mreq",  32'(mreq0.req), 32'd1);
    checkOutput("c_freed_maddr", mreq0.a.addr,   32'h108);
    checkOutput("r_rdata1",      rsp0.r.rdata,   32'hA104);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA108);
    checkOutput("c_inc_dec_same", 32'(outst0),      32'd1);
    checkOutput("a_fill_empty",   32'(fill0),       32'd0);
    checkOutput("r_rvalid_empty", 32'(rsp0.rvalid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("r_rvalid2", 32'(rsp0.rvalid), 32'd1);
    checkOutput("r_rdata2",  rsp0.r.rdata,     32'hA108);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("c_drained",  32'(outst0),      32'd0);
    checkOutput("r_drained",  32'(rsp0.rvalid), 32'd0);
    nextCycle();

    $display("[TB] streaming 16 transactions");
    sendIdx   = 0;
    grantIdx  = 0;
    recvIdx   = 0;
    cyc       = 0;
    pendValid = 1'b0;
    pendData  = '0;
    while (recvIdx < 16 && cyc < 100) begin
      applyStimulus(sendIdx < 16, 32'(sendIdx * 4), 1'b1, 1'b1, pendValid, pendData);
      if (cyc == 0) checkOutput("s_no_fallthru", 32'(mreq0.req), 32'd0);
      if (cyc == 1) checkOutput("s_first_issue", 32'(mreq0.req), 32'd1);
      nextValid = 1'b0;
      nextData  = '0;
      if (mreq0.req) begin
        checkOutput("s_grant_addr", mreq0.a.addr, 32'(grantIdx * 4));
        nextValid = 1'b1;
        nextData  = mreq0.a.addr + 32'h1000_0000;
        grantIdx++;
      end
      if (rsp0.rvalid) begin
        checkOutput("s_rdata_order", rsp0.r.rdata, 32'h1000_0000 + 32'(recvIdx * 4));
        recvIdx++;
      end
      if (sendIdx < 16 && rsp0.gnt) sendIdx++;
      nextCycle();
      pendValid = nextValid;
      pendData  = nextData;
      cyc++;
    end
    checkOutput("s_all_received", 32'(recvIdx), 32'd16);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s_end_outst", 32'(outst0), 32'd0);
    checkOutput("s_end_fill",  32'(fill0),  32'd0);
    nextCycle();

    $display("[TB] no upstream rready");
    applyStimulusAlt(1'b1, 32'h400, 1'b1, 1'b0, 32'h0);
    checkOutput("n_no_fallthru", 32'(mreq1.req), 32'd0);
    nextCycle();
    applyStimulusAlt(1'b1, 32'h404, 1'b1, 1'b0, 32'h0);
    checkOutput("n_maddr0", mreq1.a.addr, 32'h400);
    nextCycle();
    applyStimulusAlt(1'b0, 32'h0, 1'b1, 1'b1, 32'hB400);
    checkOutput("n_mreq1",  32'(mreq1.req), 32'd1);
    checkOutput("n_maddr1", mreq1.a.addr,   32'h404);
    nextCycle();
    applyStimulusAlt(1'b0, 32'h0, 1'b1, 1'b1, 32'hB404);
    checkOutput("n_rvalid0", 32'(rsp1.rvalid), 32'd1);
    checkOutput("n_rdata0",  rsp1.r.rdata,     32'hB400);
    checkOutput("n_outst2",  32'(outst1),      32'd2);
    nextCycle();
    applyStimulusAlt(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("n_rvalid1", 32'(rsp1.rvalid), 32'd1);
    checkOutput("n_rdata1",  rsp1.r.rdata,     32'hB404);
    checkOutput("n_outst1",  32'(outst1),      32'd1);
    nextCycle();
    checkOutput("n_rvalid_off", 32'(rsp1.rvalid), 32'd0);
    checkOutput("n_outst0",     32'(outst1),      32'd0);

    $display("[TB] reset with traffic buffered");
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h204, 1'b0, 1'b1, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 32'hA200);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("m_pre_fill",   32'(fill0),       32'd2);
    checkOutput("m_pre_outst",  32'(outst0),      32'd1);
    checkOutput("m_pre_rvalid", 32'(rsp0.rvalid), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("m_rvalid", 32'(rsp0.rvalid), 32'd0);
    checkOutput("m_mreq",   32'(mreq0.req),   32'd0);
    checkOutput("m_fill",   32'(fill0),       32'd0);
    checkOutput("m_outst",  32'(outst0),      32'd0);
    checkOutput("m_gnt",    32'(rsp0.gnt),    32'd1);
    checkOutput("m_rdata",  rsp0.r.rdata,     32'd0);
    @(negedge clk);
    rstN = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("m_new_mreq",  32'(mreq0.req), 32'd1);
    checkOutput("m_new_maddr", mreq0.a.addr,   32'h300);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA300);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("m_new_rvalid", 32'(rsp0.rvalid), 32'd1);
    checkOutput("m_new_rdata",  rsp0.r.rdata,     32'hA300);
    checkOutput("m_new_outst",  32'(outst0),      32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("m_done_outst",  32'(outst0),      32'd0);
    checkOutput("m_done_rvalid", 32'(rsp0.rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
